// File: rtl/n64_pkg.sv
// Shared types and timing constants for the N64 controller poller.
// Cell phases are expressed in microseconds and scaled by the clock rate.
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_BIT,
    RX_STOP
  } n64_poll_state_t;

  localparam logic [7:0] N64_CMD_POLL  = 8'h01;
  localparam int         N64_RESP_BITS = 32;

  localparam int TX_SHORT_US  = 1;
  localparam int TX_LONG_US   = 3;
  localparam int RX_SAMPLE_US = 2;
  localparam int CELL_US      = 4;
  localparam int TX_STOP_US   = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for the controller line with edge detect.
// Flops reset high to match the idle (pulled-up) line.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic line_s,
  output logic fall,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign line_s = s2_q;
  assign fall   = s3_q & ~s2_q;
  assign rise   = ~s3_q & s2_q;

endmodule

// File: rtl/n64_cntlr_poller.sv
// Periodically sends the status command to an N64 controller and
// captures its 32-bit reply over the open-drain data line.
module n64_cntlr_poller
  import n64_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int POLL_PERIOD_US = 16_667,
  parameter int RX_TIMEOUT_US  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_in,
  output logic        data_oe,
  output logic [31:0] cntlr_data,
  output logic        cntlr_data_rdy,
  output logic        cntlr_timeout
);

  localparam int US       = CLK_FREQ_HZ / 1_000_000;
  localparam int POLL_CYC = POLL_PERIOD_US * US;
  localparam int PW       = $clog2(POLL_CYC);

  localparam logic [PW-1:0] POLL_END = PW'(POLL_CYC - 1);
  localparam logic [15:0] CELL_END = 16'(CELL_US * US - 1);
  localparam logic [15:0] STOP_END = 16'(TX_STOP_US * US - 1);
  localparam logic [15:0] SHORT_C  = 16'(TX_SHORT_US * US);
  localparam logic [15:0] LONG_C   = 16'(TX_LONG_US * US);
  localparam logic [15:0] SAMP_AT  = 16'(RX_SAMPLE_US * US - 1);
  localparam logic [15:0] TO_END   = 16'(RX_TIMEOUT_US * US - 1);
  localparam logic [4:0]  LAST_BIT = 5'(N64_RESP_BITS - 1);

  n64_poll_state_t state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [15:0]   ph_q, ph_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    rxn_q, rxn_d;
  logic          fell_q, fell_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   data_q, data_d;
  logic          oe_q, oe_d;
  logic          rdy_q, rdy_d;
  logic          to_q, to_d;
  logic          rx_done, rx_abort;
  logic          line_s, fall, rise;

  sync2 u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (data_in),
    .line_s (line_s),
    .fall   (fall),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      poll_q  <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
      rxn_q   <= '0;
      fell_q  <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      rxn_q   <= rxn_d;
      fell_q  <= fell_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    poll_d   = '0;
    ph_d     = ph_q + 16'd1;
    idx_d    = idx_q;
    rxn_d    = rxn_q;
    fell_d   = fell_q;
    shift_d  = shift_q;
    rx_done  = 1'b0;
    rx_abort = 1'b0;
    unique case (state_q)
      IDLE: begin
        ph_d    = '0;
        rxn_d   = '0;
        fell_d  = 1'b0;
        shift_d = '0;
        if (poll_q == POLL_END) begin
          state_d = TX_BIT;
          idx_d   = 3'd7;
        end else begin
          poll_d = poll_q + PW'(1);
        end
      end
      TX_BIT: begin
        if (ph_q == CELL_END) begin
          ph_d = '0;
          if (idx_q == 3'd0) state_d = TX_STOP;
          else idx_d = idx_q - 3'd1;
        end
      end
      TX_STOP: begin
        if (ph_q == STOP_END) begin
          ph_d    = '0;
          state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (fall) begin
          ph_d    = '0;
          state_d = RX_BIT;
        end else if (ph_q == TO_END) begin
          state_d  = IDLE;
          rx_abort = 1'b1;
        end
      end
      RX_BIT: begin
        if (ph_q == SAMP_AT) shift_d = {shift_q[30:0], line_s};
        // a '1' cell has already risen by the sample point
        if (ph_q > SAMP_AT && line_s) begin
          ph_d = '0;
          if (rxn_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            rxn_d   = rxn_q + 5'd1;
            state_d = RX_WAIT;
          end
        end else if (ph_q == TO_END) begin
          state_d  = IDLE;
          rx_abort = 1'b1;
        end
      end
      RX_STOP: begin
        if (!fell_q && fall) begin
          fell_d = 1'b1;
          ph_d   = '0;
        end else if (fell_q && rise) begin
          state_d = IDLE;
          rx_done = 1'b1;
        end else if (ph_q == TO_END) begin
          state_d  = IDLE;
          rx_abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oe_d = 1'b0;
    unique case (state_d)
      TX_BIT:  oe_d = ph_d < (N64_CMD_POLL[idx_d] ? SHORT_C : LONG_C);
      TX_STOP: oe_d = ph_d < SHORT_C;
      default: oe_d = 1'b0;
    endcase
    rdy_d  = rx_done;
    to_d   = rx_abort;
    data_d = rx_done ? shift_q : data_q;
  end

  assign data_oe        = oe_q;
  assign cntlr_data     = data_q;
  assign cntlr_data_rdy = rdy_q;
  assign cntlr_timeout  = to_q;

endmodule
